// File: rtl/demux_9bit_stream_pkg.sv
// Shared types and constants for the 9-bit 1:4 stream demultiplexer.
package demux_9bit_pkg;

  localparam int WIDTH     = 9;
  localparam int NUM_LANES = 4;

  typedef logic [1:0]       lane_sel_t;
  typedef logic [WIDTH-1:0] word_t;

  localparam lane_sel_t LANE_A = 2'd0;
  localparam lane_sel_t LANE_B = 2'd1;
  localparam lane_sel_t LANE_C = 2'd2;
  localparam lane_sel_t LANE_D = 2'd3;

endpackage

// File: rtl/demux_9bit_stream_lane_fifo.sv
// Per-lane FIFO with a registered head word; a full lane refuses a push
// even when it pops in the same cycle, so there is never a pass-through.
module lane_fifo_9bit #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_dout;
  logic [PW-1:0]    w_rd_next;
  logic             w_push;
  logic             w_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign w_push    = push && !full;
  assign w_pop     = pop && !empty;
  assign w_rd_next = r_rd_ptr + PW'(1);
  assign level     = r_level;
  assign dout      = r_dout;

  // NOTE: storage is left unreset; r_dout is the only data register seen outside.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // Head register follows the next entry, or the incoming word when it becomes the head.
      if (w_pop) begin
        if (r_level > LW'(1))  r_dout <= r_mem[w_rd_next];
        else if (w_push)       r_dout <= din;
      end else if (w_push && empty) begin
        r_dout <= din;
      end
    end
  end

endmodule

// File: rtl/demux_9bit_stream.sv
// Routes one word per cycle to lane A-D by select; each lane buffers in its
// own FIFO and drains on an independent valid/ready handshake.
module demux_9bit_stream
  import demux_9bit_pkg::*;
#(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic [3:0]       valid,
  input  logic [3:0]       ready,
  output logic [WIDTH-1:0] outputA,
  output logic [WIDTH-1:0] outputB,
  output logic [WIDTH-1:0] outputC,
  output logic [WIDTH-1:0] outputD,
  output logic [4*LW-1:0]  level
);

  lane_sel_t        w_sel;
  logic [3:0]       w_push;
  logic [3:0]       w_pop;
  logic [3:0]       w_full;
  logic [3:0]       w_empty;
  logic [WIDTH-1:0] w_dout [NUM_LANES];

  assign w_sel    = lane_sel_t'(select);
  assign in_ready = !reset && !flush && !w_full[w_sel];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_push[g] = in_valid && in_ready && (w_sel == lane_sel_t'(g));
    assign w_pop[g]  = ready[g] && !w_empty[g];
    assign valid[g]  = !w_empty[g];

    lane_fifo_9bit #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .push (w_push[g]),
      .din  (in),
      .pop  (w_pop[g]),
      .dout (w_dout[g]),
      .empty(w_empty[g]),
      .full (w_full[g]),
      .level(level[g*LW +: LW])
    );
  end

  assign outputA = w_dout[LANE_A];
  assign outputB = w_dout[LANE_B];
  assign outputC = w_dout[LANE_C];
  assign outputD = w_dout[LANE_D];

endmodule

// File: doc/demux_9bit_stream.md
Name: demux_9bit_stream

Overview:
- Inverse of the ALU's 4:1 9-bit operand mux.
- Accepts one 9-bit word per cycle on a valid/ready input and routes it to one of four output lanes (A-D) chosen by a 2-bit select.
- Each lane buffers words in its own small FIFO and presents them on an independent valid/ready output.
- Sits between the ALU result path and the four downstream consumers, absorbing per-consumer backpressure.

Parameters:
- WIDTH, 9, data word width.
- DEPTH, 2, entries per lane FIFO; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all lane FIFOs.
- select  input  2  destination lane: 00=A, 01=B, 10=C, 11=D.
- in_valid  input  1  input word present.
- in_ready  output  1  selected lane can accept.
- in  input  WIDTH  input word.
- valid  output  4  per-lane head valid; bit0=A … bit3=D.
- ready  input  4  per-lane consumer ready; bit0=A … bit3=D.
- outputA  output  WIDTH  lane A head word.
- outputB  output  WIDTH  lane B head word.
- outputC  output  WIDTH  lane C head word.
- outputD  output  WIDTH  lane D head word.
- level  output  4x($clog2(DEPTH)+1)  per-lane occupancy.

Behaviour:
- Reset (reset=1 at an edge):
  - all lanes empty; valid=0000; level=0 for every lane.
  - outputA-D=0; pointers=0.
  - in_ready=0 while reset is high.
- in_ready:
  - combinational: !reset && !flush && !full[select].
  - depends only on select and the full flags, not on in_valid.
- Push: at an edge with in_valid && in_ready, word `in` is written to the tail of lane[select]. Exactly one lane is written per cycle; other lanes are unaffected.
- Pop: at an edge with valid[i] && ready[i], lane i advances its head. All four lanes may pop in the same cycle.
- valid[i] = (level[i] != 0).
- Head data:
  - output{A..D} shows the head entry, registered storage read.
  - when a lane is empty, its output holds the last head value; it is don't-care but must not be X after reset.
- Latency: a word accepted at edge N is visible with valid=1 in cycle N+1. There is no combinational in→out path.
- Ordering: strict FIFO order per lane. No ordering guarantee across lanes.
- Full lane:
  - push is refused even if the same lane pops that cycle; no pass-through.
  - the word remains on `in`; upstream holds it.
- Empty lane with simultaneous push and pop: the pop is not possible (valid=0); the push proceeds.
- Non-full, non-empty lane with simultaneous push and pop: level unchanged, head advances, tail advances.
- Pointer wrap: modulo DEPTH via $clog2(DEPTH) bits. level counts 0..DEPTH; full = (level==DEPTH).
- select changing while in_valid=1 and in_ready=0 is legal. The word goes to whichever lane select names at the accepting edge.
- flush:
  - priority over push and pop.
  - empties all lanes at that edge; valid=0000 next cycle.
  - output data retain their values.
- reset has priority over flush.
- reset mid-operation: in-flight words are discarded and there is no partial write; the state equals the post-reset state above.

Decomposition:
- Package demux_9bit_pkg:
  - WIDTH default constant.
  - typedef lane_sel_t (logic [1:0]).
  - localparams LANE_A=0 … LANE_D=3.
  - typedef word_t (logic [WIDTH-1:0]).
- One sub-module, lane_fifo_9bit:
  - ports: clk, reset, flush, push, din, pop, dout, empty, full, level.
  - instantiated four times by generate.
- Top-level logic: select decode to push enables, in_ready mux, lane output wiring.

Test Plan:
1. Reset then route: reset=1 for 2 cycles; select=00/01/10/11 with in=1,2,3,4, ready=1111 → valid bit i high one cycle after each push; outputA=1, outputB=2, outputC=3, outputD=4; in_ready=1 throughout.
2. Backpressure fill, DEPTH=2: ready[1]=0; push 9'd5, 9'd6, 9'd7 to lane B → in_ready=0 on the third word, level B=2. Raise ready[1] → outputs 5 then 6; 7 accepted only after the first pop; order 5,6,7.
3. Full lane with simultaneous pop: lane C full (10, 11); ready[2]=1, push 12 to C in the same cycle → push refused (in_ready=0), C pops 10, level=1; next cycle 12 accepted.
4. Cross-lane independence: lane A full with ready[0]=0; push 9'h1FF to D → accepted immediately; valid=1001; outputD=511; lane A unchanged.
5. Flush: lanes A and B hold data; assert flush with in_valid=1, select=00 → in_ready=0, valid=0000 next cycle, all level=0, the flushed-cycle word is not stored.
6. Mid-stream reset: lane D at level 2 and pushing; reset=1 for one cycle → valid=0000, outputs=0, level=0; first push afterwards appears as the new head.
